bcd_countdown_timer: RTL

- Parametrised multi-digit BCD countdown timer, MM:SS style; successor to the single-digit mod-10 counter.
- Holds seconds-ones (mod 10), seconds-tens (mod SEC_TENS_MOD) and MIN_DIGITS minute digits (mod 10 each).
- Supports parallel load, keypad digit-shift entry, prescaled countdown with pause, and a completion pulse.
- Sits between the keypad/controller FSM and the display driver and magnetron-enable logic of the microwave.

---
 rtl/bcd_countdown_timer_if.sv | 27 ++
 rtl/bcd_countdown_timer.sv | 106 ++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle between the keypad/controller FSM and the BCD
// countdown timer. The controller side is the master and the timer is the slave.
interface bcd_countdown_timer_if #(
    parameter int MIN_DIGITS = 2
);
    localparam int W = 4 * (MIN_DIGITS + 2);

    logic         loadn;      // synchronous active-low parallel load
    logic [W-1:0] data;       // parallel load value, digit0 = seconds-ones
    logic         shift_en;   // keypad digit entry strobe
    logic [3:0]   key_digit;  // keypad digit value
    logic         en;         // count enable (magnetron on)
    logic [W-1:0] count;      // current BCD value
    logic         zero;       // count == 0
    logic         tc;         // terminal count = en & zero
    logic         done;       // one-cycle completion pulse

    modport master (
        output loadn, data, shift_en, key_digit, en,
        input  count, zero, tc, done
    );

    modport slave (
        input  loadn, data, shift_en, key_digit, en,
        output count, zero, tc, done
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer (MM:SS style) for the microwave controller.
// Digit order from the LSB: seconds-ones, seconds-tens, then MIN_DIGITS
// minute digits. Supports parallel load with clamping, keypad digit-shift
// entry, prescaled countdown with phase-preserving pause, and a registered
// completion pulse.
module bcd_countdown_timer #(
    parameter int MIN_DIGITS   = 2,
    parameter int SEC_TENS_MOD = 6,
    parameter int PRESCALE     = 1
) (
    input logic                clock,
    input logic                clear,
    bcd_countdown_timer_if.slave bus
);
    localparam int NUM_DIGITS = MIN_DIGITS + 2;
    localparam int W          = 4 * NUM_DIGITS;
    localparam int PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      TENS_WRAP = 4'(SEC_TENS_MOD - 1);

    logic [W-1:0]    count_q, count_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            done_q, done_d;
    logic            zero;
    logic [W-1:0]    count_dec;

    // Force every digit above 9 down to 9; valid digits pass through.
    function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (value[i*4 +: 4] > 4'd9)
                result[i*4 +: 4] = 4'd9;
        end
        return result;
    endfunction

    // One BCD decrement with a borrow chain starting at seconds-ones.
    // Seconds-tens wraps to SEC_TENS_MOD-1, every other digit wraps to 9.
    // A non-canonical seconds-tens (>= SEC_TENS_MOD) just decrements.
    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (value[i*4 +: 4] != 4'd0) begin
                    result[i*4 +: 4] = value[i*4 +: 4] - 4'd1;
                    borrow           = 1'b0;
                end else begin
                    result[i*4 +: 4] = (i == 1) ? TENS_WRAP : 4'd9;
                end
            end
        end
        return result;
    endfunction

    assign zero      = (count_q == '0);
    assign count_dec = bcd_decrement(count_q);

    // Next-state selection: load beats shift, shift beats countdown.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the
        // combinational block never holds a value, which would infer a latch.
        count_d = count_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
        if (!bus.loadn) begin
            count_d = clamp_digits(bus.data);
            ps_d    = '0;
        end else if (bus.shift_en && !bus.en && (bus.key_digit <= 4'd9)) begin
            count_d = {count_q[W-5:0], bus.key_digit};
            ps_d    = '0;
        end else if (bus.en && !zero) begin
            if (ps_q == PS_LAST) begin
                count_d = count_dec;
                ps_d    = '0;
                done_d  = (count_dec == '0);
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // State registers with asynchronous clear; all digits update together.
    always_ff @(posedge clock or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values and updates on the same edge.
        if (clear) begin
            count_q <= '0;
            ps_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.zero  = zero;
    assign bus.tc    = bus.en & zero;
    assign bus.done  = done_q;
endmodule
